// File: rtl/fib_text_pkg.sv
// Shared types and ASCII constants for the Fibonacci text line sequencer.
package fib_text_pkg;

  typedef enum logic [2:0] {
    RENDER,
    CONVERT,
    WRITE,
    WAIT,
    ADVANCE,
    HALT
  } state_t;

  localparam logic [7:0] CH_F     = 8'h46;
  localparam logic [7:0] CH_I     = 8'h49;
  localparam logic [7:0] CH_B     = 8'h42;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_N     = 8'h4E;
  localparam logic [7:0] CH_E     = 8'h45;

  // Fixed four-character prefix: "FIB:" for values, "DONE" once the sequence ends.
  function automatic logic [7:0] header_char(input logic done_text, input logic [1:0] pos);
    case ({done_text, pos})
      3'b000:  return CH_F;
      3'b001:  return CH_I;
      3'b010:  return CH_B;
      3'b011:  return CH_COLON;
      3'b100:  return CH_D;
      3'b101:  return CH_O;
      3'b110:  return CH_N;
      default: return CH_E;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 12-bit binary to 4 BCD digits, valid 12 cycles after start.
module bin2bcd_seq (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] bin,
  output logic        valid,
  output logic [15:0] bcd
);

  logic [27:0] shift_reg;
  logic [3:0]  shift_cnt;
  logic        active;

  function automatic logic [27:0] dabble_step(input logic [27:0] z);
    logic [27:0] t;
    t = z;
    for (int d = 0; d < 4; d++) begin
      if (t[12 + 4*d +: 4] >= 4'd5)
        t[12 + 4*d +: 4] = t[12 + 4*d +: 4] + 4'd3;
    end
    return {t[26:0], 1'b0};
  endfunction

  // The load edge already performs the first shift (no add-3 is needed on all-zero digits),
  // so eleven further shifts finish the conversion twelve edges after start.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      shift_cnt <= '0;
      active    <= 1'b0;
      valid     <= 1'b0;
    end else if (start) begin
      shift_reg <= {15'd0, bin, 1'b0};
      shift_cnt <= 4'd1;
      active    <= 1'b1;
      valid     <= 1'b0;
    end else if (active) begin
      shift_reg <= dabble_step(shift_reg);
      shift_cnt <= shift_cnt + 4'd1;
      if (shift_cnt == 4'd11) begin
        active <= 1'b0;
        valid  <= 1'b1;
      end
    end
  end

  assign bcd = shift_reg[27:12];

endmodule

// File: rtl/fib_text_sequencer.sv
// Steps the Fibonacci sequence on a prescaled tick and streams "FIB:<n>" / "DONE"
// into the character RAM one accepted write at a time.
module fib_text_sequencer #(
  parameter int         TICK_DIV   = 25000000,
  parameter logic [6:0] TEXT_LINE  = 7'd2,
  parameter logic [6:0] TEXT_COL0  = 7'd0,
  parameter int         N_COLS     = 12,
  parameter int         LAST_INDEX = 14
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        restart,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [11:0] fib_value,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  import fib_text_pkg::*;

  localparam int         PRESC_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] LAST_COL = 4'(N_COLS - 1);
  localparam logic [7:0] LAST_IDX = 8'(LAST_INDEX);

  state_t             state, state_next;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic               pending;
  logic               done_text;
  logic [3:0]         col;
  logic [7:0]         index;
  logic [11:0]        a, b;
  logic               bcd_start, bcd_valid;
  logic [11:0]        bcd_bin;
  logic [15:0]        bcd;
  logic [2:0]         num_digits;
  logic [3:0]         digit_pos, digit_sel, digit;
  logic [7:0]         char_k;

  assign tick = enable && (presc == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset)
      presc <= '0;
    else if (!enable || tick)
      presc <= '0;
    else
      presc <= presc + PRESC_W'(1);
  end

  // ADVANCE updates fib_value on the same edge the converter loads, so feed it the new value.
  assign bcd_bin = (state == ADVANCE) ? b : fib_value;

  bin2bcd_seq u_bcd (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .start       (bcd_start),
    .bin         (bcd_bin),
    .valid       (bcd_valid),
    .bcd         (bcd)
  );

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset)
      state <= RENDER;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    bcd_start  = 1'b0;
    unique case (state)
      RENDER: begin
        state_next = CONVERT;
        bcd_start  = 1'b1;
      end
      CONVERT: if (bcd_valid) state_next = WRITE;
      WRITE:   if (wr_ready && col == LAST_COL) state_next = done_text ? HALT : WAIT;
      WAIT:    if (tick || pending) state_next = ADVANCE;
      ADVANCE: begin
        if (index == LAST_IDX) begin
          state_next = WRITE;
        end else begin
          state_next = CONVERT;
          bcd_start  = 1'b1;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RENDER;
    endcase
    if (restart) begin
      state_next = RENDER;
      bcd_start  = 1'b0;
    end
  end

  // Fibonacci registers, one-deep tick buffer and column counter; restart outranks any tick.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      index     <= '0;
      a         <= '0;
      b         <= 12'd1;
      fib_value <= '0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
      done_text <= 1'b0;
      col       <= '0;
    end else if (restart) begin
      index     <= '0;
      a         <= '0;
      b         <= 12'd1;
      fib_value <= '0;
      pending   <= 1'b0;
      done_text <= 1'b0;
      col       <= '0;
    end else begin
      case (state)
        WAIT: pending <= pending && tick;
        HALT: pending <= pending;
        default: begin
          if (tick) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
          end
        end
      endcase
      if (state == ADVANCE) begin
        if (index == LAST_IDX) begin
          done_text <= 1'b1;
        end else begin
          a         <= b;
          b         <= a + b;
          index     <= index + 8'd1;
          fib_value <= b;
        end
      end
      if (state == WRITE && wr_ready)
        col <= (col == LAST_COL) ? 4'd0 : col + 4'd1;
    end
  end

  // Character for column k: prefix, then significant digits only, then space padding.
  always_comb begin
    num_digits = (bcd[15:12] != 4'd0) ? 3'd4 :
                 (bcd[11:8]  != 4'd0) ? 3'd3 :
                 (bcd[7:4]   != 4'd0) ? 3'd2 : 3'd1;
    digit_pos  = col - 4'd4;
    digit_sel  = {1'b0, num_digits} - 4'd1 - digit_pos;
    case (digit_sel)
      4'd0:    digit = bcd[3:0];
      4'd1:    digit = bcd[7:4];
      4'd2:    digit = bcd[11:8];
      4'd3:    digit = bcd[15:12];
      default: digit = bcd[3:0];
    endcase
    char_k = CH_SPACE;
    if (col < 4'd4)
      char_k = header_char(done_text, col[1:0]);
    else if (!done_text && digit_pos < {1'b0, num_digits})
      char_k = CH_ZERO + {4'd0, digit};
  end

  assign wr_en   = (state == WRITE);
  assign busy    = (state == CONVERT) || (state == WRITE);
  assign done    = (state == HALT);
  assign wr_addr = wr_en ? {TEXT_LINE, TEXT_COL0 + 7'(col)} : 14'd0;
  assign wr_data = wr_en ? char_k : 8'd0;

endmodule
